// File: rtl/divider_32_bit.sv
// ---------------------------------------------------------------------------
// divider_32_bit
// Unsigned 32-bit restoring shift/subtract divider. One quotient bit is
// produced per clock, so a nonzero-divisor division takes 32 cycles from
// the accepting edge to the done pulse. A zero divisor finishes on the
// accepting edge with quotient all ones, remainder equal to the dividend
// and div_by_zero raised.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   start        request to begin a division (accepted in IDLE or DONE)
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle pulse when quotient/remainder become valid
//   quotient     registered unsigned quotient
//   remainder    registered unsigned remainder
//   div_by_zero  high alongside the results of a divide-by-zero
// ---------------------------------------------------------------------------
module divider_32_bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;

    // The dividend shift register doubles as the quotient accumulator:
    // each iteration consumes the MSB as the next dividend bit and shifts
    // the freshly computed quotient bit into the LSB, so after 32
    // iterations it holds the whole quotient.
    logic [31:0] dvd_shift;
    logic [31:0] dvs_reg;

    // The partial remainder is always strictly less than the divisor after
    // an iteration, so only its low 32 bits are stored; the 33rd bit only
    // exists transiently in the shifted/trial values below.
    logic [31:0] part_rem;
    logic [5:0]  iter_count;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] next_rem;
    logic        q_bit;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, try subtracting the divisor, and keep the
    // difference only when it did not go negative.
    always_comb begin
        shifted  = {part_rem, dvd_shift[31]};
        trial    = shifted - {1'b0, dvs_reg};
        q_bit    = ~trial[32];
        next_rem = q_bit ? trial[31:0] : shifted[31:0];
    end

    // Control state machine and datapath registers. done defaults low every
    // cycle so it can only ever be a single-cycle pulse. Results are only
    // written on completion, so they never show intermediate values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dvd_shift   <= 32'd0;
            dvs_reg     <= 32'd0;
            part_rem    <= 32'd0;
            iter_count  <= 6'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_shift   <= dividend;
                        dvs_reg     <= divisor;
                        part_rem    <= 32'd0;
                        iter_count  <= 6'd0;
                        div_by_zero <= (divisor == 32'd0);
                        if (divisor != 32'd0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            // Zero divisor short-circuits straight to DONE
                            // without ever raising busy.
                            state     <= DONE;
                            quotient  <= 32'hFFFF_FFFF;
                            remainder <= dividend;
                            done      <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here, so a
                    // request during a division has no effect.
                    part_rem   <= next_rem;
                    dvd_shift  <= {dvd_shift[30:0], q_bit};
                    iter_count <= iter_count + 6'd1;
                    if (iter_count == 6'd31) begin
                        quotient  <= {dvd_shift[30:0], q_bit};
                        remainder <= next_rem;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32_bit.sv
// ---------------------------------------------------------------------------
// tb_divider_32_bit
// Self-checking bench for divider_32_bit: a table of directed divisions
// with hand-computed results, followed by hand-written sequences for the
// start-while-busy, reset-abort and back-to-back (start held high) cases.
// ---------------------------------------------------------------------------
module tb_divider_32_bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs [10];

    divider_32_bit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and log a
    // FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present operands with start high at a falling edge, let the next
    // rising edge accept them, then drop start just after that edge.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Starting just after the accepting edge, count rising edges until done
    // is seen (bounded), and count the samples in which busy was high.
    task automatic waitDone(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy && !done) busy_cnt++;
        end
    endtask

    int lat;
    int bcnt;
    int exp_lat;
    int done_seen;

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[2] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[7] = '{32'd305419896,  32'd1000,       32'd305419,     32'd896,        1'b0};
        vecs[8] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[9] = '{32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        checkOutput("reset_busy",      {31'd0, busy},        32'd0);
        checkOutput("reset_done",      {31'd0, done},        32'd0);
        checkOutput("reset_quotient",  quotient,             32'd0);
        checkOutput("reset_remainder", remainder,            32'd0);
        checkOutput("reset_dbz",       {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].dvd, vecs[i].dvs);
            waitDone(lat, bcnt);
            exp_lat = (vecs[i].dvs == 32'd0) ? 0 : 32;
            checkOutput($sformatf("vec%0d_latency", i),   lat,       exp_lat);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bcnt,    exp_lat);
            checkOutput($sformatf("vec%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
            checkOutput($sformatf("vec%0d_quotient", i),  quotient,  vecs[i].exp_q);
            checkOutput($sformatf("vec%0d_remainder", i), remainder, vecs[i].exp_r);
            checkOutput($sformatf("vec%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            checkOutput($sformatf("vec%0d_hold_q", i), quotient, vecs[i].exp_q);
        end

        // A second start pulsed ten edges into a division must be ignored.
        $display("[TB] start while busy");
        applyStimulus(32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        dividend = 32'd8;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ignore_busy", {31'd0, busy}, 32'd1);
        waitDone(lat, bcnt);
        checkOutput("ignore_latency",   lat + 10,  32'd32);
        checkOutput("ignore_quotient",  quotient,  32'd333);
        checkOutput("ignore_remainder", remainder, 32'd1);
        @(posedge clk);
        #1;

        // Reset ten edges into a division aborts it with no done pulse.
        $display("[TB] reset during run");
        applyStimulus(32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_busy",      {31'd0, busy},        32'd0);
        checkOutput("abort_done",      {31'd0, done},        32'd0);
        checkOutput("abort_quotient",  quotient,             32'd0);
        checkOutput("abort_remainder", remainder,            32'd0);
        checkOutput("abort_dbz",       {31'd0, div_by_zero}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 32'd0);
        applyStimulus(32'd9, 32'd4);
        waitDone(lat, bcnt);
        checkOutput("post_reset_latency",   lat,       32'd32);
        checkOutput("post_reset_quotient",  quotient,  32'd2);
        checkOutput("post_reset_remainder", remainder, 32'd1);
        @(posedge clk);
        #1;

        // start held high: the second operation is accepted in the DONE cycle.
        $display("[TB] back-to-back with start held");
        @(negedge clk);
        dividend = 32'd20;
        divisor  = 32'd6;
        start    = 1'b1;
        @(posedge clk);
        #1;
        waitDone(lat, bcnt);
        checkOutput("b2b_first_latency",   lat,       32'd32);
        checkOutput("b2b_first_quotient",  quotient,  32'd3);
        checkOutput("b2b_first_remainder", remainder, 32'd2);
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        checkOutput("b2b_accept_busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b_hold_q",      quotient,      32'd3);
        checkOutput("b2b_hold_r",      remainder,     32'd2);
        waitDone(lat, bcnt);
        start = 1'b0;
        checkOutput("b2b_second_latency",   lat,       32'd32);
        checkOutput("b2b_second_quotient",  quotient,  32'd10);
        checkOutput("b2b_second_remainder", remainder, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_return_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
